// File: rtl/eth_pkg.sv
// Shared constants, header byte offsets and filter FSM states for the Ethernet ingress path.
// Pure definitions; no timing of its own.
// Not applicable (no handshake in a package).
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;

    // Byte offsets within the head beat; fields are big-endian on the wire.
    localparam int OFF_ETHTYPE  = 12;
    localparam int OFF_IPV4_LEN = 16;
    localparam int OFF_IPV6_LEN = 18;

    localparam int BEAT_CNT_W = 9;
    localparam int EXP_W      = 17;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } filt_state_t;

    // Beats a frame of 'len' bytes should occupy: max(1, ceil(len/beat_bytes)).
    // Carried in 17 bits so len + beat_bytes - 1 cannot overflow.
    function automatic logic [EXP_W-1:0] calc_exp_beats(input logic [15:0] len,
                                                         input int unsigned beat_bytes);
        logic [EXP_W-1:0] q;
        q = ({1'b0, len} + EXP_W'(beat_bytes) - EXP_W'(1)) / EXP_W'(beat_bytes);
        return (q == '0) ? EXP_W'(1) : q;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered ready/valid buffer; payload passes through unmodified.
// Latency 1 cycle from input handshake to output valid when empty; 1 beat/cycle sustained.
// Input ready is purely registered (not-full), so it never depends combinationally on i_m_rdy.
module axis_skid_buf #(
    parameter int WIDTH = 513
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_s_dat,
    input  logic             i_s_vld,
    output logic             o_s_rdy,
    output logic [WIDTH-1:0] o_m_dat,
    output logic             o_m_vld,
    input  logic             i_m_rdy
);

    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_d0;   // output (oldest) entry
    logic [WIDTH-1:0] r_d1;   // skid entry, only valid when r_cnt == 2
    logic             w_push;
    logic             w_pop;

    assign o_s_rdy = (r_cnt != 2'd2);
    assign o_m_vld = (r_cnt != 2'd0);
    assign o_m_dat = r_d0;
    assign w_push  = i_s_vld & o_s_rdy;
    assign w_pop   = o_m_vld & i_m_rdy;

    // Occupancy and storage; r_d0 only changes when empty or on a pop, so output holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_d0  <= i_s_dat;
                        r_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_d0 <= i_s_dat;
                    end else if (w_push) begin
                        r_d1  <= i_s_dat;
                        r_cnt <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_d0  <= r_d1;
                        r_cnt <= 2'd1;
                    end
                end
                default: r_cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/eth_ingress_filter.sv
// Forwards IPv4/IPv6 frames through a skid buffer, consumes all others, counts pass/drop/length errors.
// Latency 1 cycle (s_axis handshake to m_axis valid) when buffer empty; 1 beat/cycle back-to-back.
// Forwarded beats follow buffer space; dropped frames are accepted every cycle regardless of m_axis_tready.
module eth_ingress_filter
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  pass_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [CNT_WIDTH-1:0]  len_err_cnt
);

    localparam int unsigned           BEAT_BYTES = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = 1;
    localparam logic [BEAT_CNT_W-1:0] BEATS_MAX  = '1;

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    filt_state_t           r_state;
    logic [BEAT_CNT_W-1:0] r_beats;
    logic [EXP_W-1:0]      r_exp;
    logic [CNT_WIDTH-1:0]  r_pass;
    logic [CNT_WIDTH-1:0]  r_drop;
    logic [CNT_WIDTH-1:0]  r_lerr;

    logic [15:0]           w_ethtype;
    logic [15:0]           w_len;
    logic                  w_is_v4;
    logic                  w_is_v6;
    logic                  w_fwd;
    logic [EXP_W-1:0]      w_exp;
    logic                  w_buf_rdy;
    logic                  w_s_rdy;
    logic                  w_hs;
    logic                  w_in_head;
    logic                  w_push;
    logic                  w_fwd_last;
    logic                  w_drop_last;
    logic [BEAT_CNT_W-1:0] w_beats_now;
    logic [EXP_W-1:0]      w_exp_now;
    logic                  w_len_err;

    // Reset asserts immediately but releases only after two clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    // Head-beat field extraction and classification (only meaningful in HEAD).
    assign w_ethtype = {s_axis_tdata[OFF_ETHTYPE*8 +: 8],      s_axis_tdata[(OFF_ETHTYPE+1)*8 +: 8]};
    assign w_is_v4   = (w_ethtype == ETH_TYPE_IPV4);
    assign w_is_v6   = (w_ethtype == ETH_TYPE_IPV6);
    assign w_fwd     = cfg_enable & (w_is_v4 | w_is_v6);
    assign w_len     = w_is_v4 ? {s_axis_tdata[OFF_IPV4_LEN*8 +: 8], s_axis_tdata[(OFF_IPV4_LEN+1)*8 +: 8]}
                               : {s_axis_tdata[OFF_IPV6_LEN*8 +: 8], s_axis_tdata[(OFF_IPV6_LEN+1)*8 +: 8]};
    assign w_exp     = calc_exp_beats(w_len, BEAT_BYTES);

    // Upstream ready: drop path always accepts; forward path follows buffer space; held low in reset.
    always_comb begin
        w_s_rdy = 1'b0;
        case (r_state)
            HEAD:    w_s_rdy = !w_fwd || w_buf_rdy;
            PASS:    w_s_rdy = w_buf_rdy;
            DROP:    w_s_rdy = 1'b1;
            default: w_s_rdy = 1'b0;
        endcase
        w_s_rdy = w_s_rdy & w_rst_n;
    end
    assign s_axis_tready = w_s_rdy;

    assign w_hs        = s_axis_tvalid & w_s_rdy;
    assign w_in_head   = (r_state == HEAD);
    assign w_push      = w_hs & ((w_in_head & w_fwd) | (r_state == PASS));
    assign w_fwd_last  = w_push & s_axis_tlast;
    assign w_drop_last = w_hs & s_axis_tlast & ((w_in_head & !w_fwd) | (r_state == DROP));

    // Beat count including the current beat, saturating so very long frames still read as a mismatch.
    assign w_beats_now = w_in_head ? BEAT_CNT_W'(1)
                                   : ((r_beats == BEATS_MAX) ? r_beats : r_beats + BEAT_CNT_W'(1));
    assign w_exp_now   = w_in_head ? w_exp : r_exp;
    assign w_len_err   = w_fwd_last & ({{(EXP_W-BEAT_CNT_W){1'b0}}, w_beats_now} != w_exp_now);

    // Frame FSM: decision latched on the head beat, cfg_enable ignored until the next head.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= HEAD;
            r_beats <= '0;
            r_exp   <= '0;
        end else if (w_hs) begin
            case (r_state)
                HEAD: begin
                    r_beats <= w_beats_now;
                    r_exp   <= w_exp;
                    if (!s_axis_tlast) begin
                        r_state <= w_fwd ? PASS : DROP;
                    end
                end
                PASS: begin
                    r_beats <= w_beats_now;
                    if (s_axis_tlast) begin
                        r_state <= HEAD;
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        r_state <= HEAD;
                    end
                end
                default: r_state <= HEAD;
            endcase
        end
    end

    // Statistics counters, free-running modulo 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pass <= '0;
            r_drop <= '0;
            r_lerr <= '0;
        end else begin
            if (w_fwd_last) begin
                r_pass <= r_pass + CNT_ONE;
            end
            if (w_drop_last) begin
                r_drop <= r_drop + CNT_ONE;
            end
            if (w_len_err) begin
                r_lerr <= r_lerr + CNT_ONE;
            end
        end
    end

    assign pass_cnt    = r_pass;
    assign drop_cnt    = r_drop;
    assign len_err_cnt = r_lerr;

    axis_skid_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .i_s_dat ({s_axis_tlast, s_axis_tdata}),
        .i_s_vld (w_push),
        .o_s_rdy (w_buf_rdy),
        .o_m_dat ({m_axis_tlast, m_axis_tdata}),
        .o_m_vld (m_axis_tvalid),
        .i_m_rdy (m_axis_tready)
    );

endmodule

// File: tb/tb_eth_ingress_filter.sv
module tb_eth_ingress_filter;

    localparam int DW = 512;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_enable;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] len_err_cnt;

    always #5 clk = ~clk;

    eth_ingress_filter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_enable    (cfg_enable),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .pass_cnt      (pass_cnt),
        .drop_cnt      (drop_cnt),
        .len_err_cnt   (len_err_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    typedef struct {
        logic [15:0] et;
        logic [15:0] len;
        int          nb;
        bit          cfg;
        int          rdy;     // 0 stalled, 1 ready, 2 toggling
        bit          fwd;     // expected: forwarded
        bit          lerr;    // expected: length error counted
        bit          chk_lat;
    } vec_t;

    beat_t exp_q[$];
    int    in_cyc_q[$];
    int    out_cyc_q[$];
    int    cyc;
    int    checks;
    int    errors;
    int    rdy_mode;
    int    e_pass, e_drop, e_lerr;
    vec_t  vecs[10];

    beat_t         mon_e;
    logic          prev_stall;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready pattern, changed just after each edge.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = ~m_tready;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Output scoreboard and stall-stability check, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(m_tvalid && m_tdata == prev_d && m_tlast == prev_l)) begin
                    errors++;
                    $display("FAIL stall_hold actual vld=%0b last=%0b required vld=1 last=%0b (data held)",
                             m_tvalid, m_tlast, prev_l);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out actual last=%0b data=%0h required none", m_tlast, m_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_tdata !== mon_e.d || m_tlast !== mon_e.l) begin
                        errors++;
                        $display("FAIL out_beat actual last=%0b data=%0h required last=%0b data=%0h",
                                 m_tlast, m_tdata, mon_e.l, mon_e.d);
                    end
                end
                out_cyc_q.push_back(cyc);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
        end
    end

    function automatic logic [DW-1:0] mk_beat(input logic [15:0] et, input logic [15:0] len, input int b);
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        if (b == 0) begin
            d[12*8 +: 8] = et[15:8];
            d[13*8 +: 8] = et[7:0];
            if (et == 16'h86DD) begin
                d[18*8 +: 8] = len[15:8];
                d[19*8 +: 8] = len[7:0];
            end else begin
                d[16*8 +: 8] = len[15:8];
                d[17*8 +: 8] = len[7:0];
            end
        end
        return d;
    endfunction

    // Drive nsend beats of an nb-beat frame (tlast only on beat nb-1); call just after a rising edge.
    task automatic send_frame(input logic [15:0] et, input logic [15:0] len, input int nb, input int nsend,
                              input bit cfg_h, input bit cfg_r, input bit fwd, output int waits);
        beat_t bt;
        waits = 0;
        for (int b = 0; b < nsend; b++) begin
            bt.d       = mk_beat(et, len, b);
            bt.l       = (b == nb - 1);
            s_tdata    = bt.d;
            s_tlast    = bt.l;
            s_tvalid   = 1'b1;
            cfg_enable = (b == 0) ? cfg_h : cfg_r;
            forever begin
                @(negedge clk);
                if (s_tready) break;
                waits++;
                if (waits > 1000) begin
                    $display("FAIL send_timeout actual s_tready=0 required 1 within 1000 cycles");
                    $fatal(1);
                end
            end
            if (fwd) begin
                exp_q.push_back(bt);
                in_cyc_q.push_back(cyc);
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_pass_cnt"}, pass_cnt, e_pass);
        chk({tag, "_drop_cnt"}, drop_cnt, e_drop);
        chk({tag, "_len_err_cnt"}, len_err_cnt, e_lerr);
    endtask

    initial begin
        int waits;
        rst_n      = 1'b0;
        cfg_enable = 1'b1;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        s_tdata    = '0;
        rdy_mode   = 0;
        e_pass = 0; e_drop = 0; e_lerr = 0;
        // ARP EtherType on the bus: the drop-decision term must stay gated during reset.
        s_tdata[12*8 +: 8] = 8'h08;
        s_tdata[13*8 +: 8] = 8'h06;

        //          et        len     nb cfg rdy fwd lerr lat
        vecs[0] = '{16'h0800, 16'd400,   7, 1, 1, 1, 0, 1};
        vecs[1] = '{16'h0806, 16'd0,     3, 1, 0, 0, 0, 0};
        vecs[2] = '{16'h86DD, 16'd800,  10, 1, 1, 1, 1, 1};
        vecs[3] = '{16'h0800, 16'd0,     1, 1, 1, 1, 0, 0};
        vecs[4] = '{16'h0800, 16'd64,    2, 1, 1, 1, 1, 0};
        vecs[5] = '{16'h0800, 16'd65,    2, 1, 2, 1, 0, 0};
        vecs[6] = '{16'h86DD, 16'd6,     2, 0, 1, 0, 0, 0};
        vecs[7] = '{16'h86DE, 16'd6,     1, 1, 1, 0, 0, 0};
        vecs[8] = '{16'h86DD, 16'hFFFF,  3, 1, 1, 1, 1, 0};
        vecs[9] = '{16'h0800, 16'd128,   2, 1, 0, 1, 0, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata_zero", (m_tdata == '0), 1);
        chk_cnts("rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("release_s_tready_low", s_tready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", s_tready, 1);
        @(posedge clk);
        #1;

        // Table-driven frames.
        for (int i = 0; i < 10; i++) begin
            in_cyc_q.delete();
            out_cyc_q.delete();
            rdy_mode = vecs[i].rdy;
            m_tready = (vecs[i].rdy == 1);
            send_frame(vecs[i].et, vecs[i].len, vecs[i].nb, vecs[i].nb,
                       vecs[i].cfg, vecs[i].cfg, vecs[i].fwd, waits);
            if (!vecs[i].fwd) begin
                chk("drop_never_stalls", waits, 0);
                chk("drop_no_m_valid", m_tvalid, 0);
            end
            e_pass += vecs[i].fwd ? 1 : 0;
            e_drop += vecs[i].fwd ? 0 : 1;
            e_lerr += vecs[i].lerr ? 1 : 0;
            drain();
            if (vecs[i].chk_lat) begin
                chk("lat_beat_count", out_cyc_q.size(), vecs[i].nb);
                for (int k = 0; k < in_cyc_q.size() && k < out_cyc_q.size(); k++)
                    chk("latency", out_cyc_q[k] - in_cyc_q[k], 1);
            end
            chk_cnts("vec");
            @(posedge clk);
            #1;
        end

        // Back-to-back single-beat frames: one output per cycle, no bubbles.
        in_cyc_q.delete();
        out_cyc_q.delete();
        rdy_mode = 1;
        m_tready = 1'b1;
        send_frame(16'h86DD, 16'd6,  1, 1, 1, 1, 1, waits);
        send_frame(16'h0800, 16'd46, 1, 1, 1, 1, 1, waits);
        send_frame(16'h86DD, 16'd6,  1, 1, 1, 1, 1, waits);
        send_frame(16'h0800, 16'd46, 1, 1, 1, 1, 1, waits);
        e_pass += 4;
        drain();
        chk("b2b_out_count", out_cyc_q.size(), 4);
        for (int k = 1; k < out_cyc_q.size(); k++)
            chk("b2b_no_bubble", out_cyc_q[k] - out_cyc_q[k-1], 1);
        chk_cnts("b2b");
        @(posedge clk);
        #1;

        // Alternating backpressure over 200 single-beat frames.
        rdy_mode = 2;
        for (int p = 0; p < 100; p++) begin
            send_frame(16'h86DD, 16'd6,  1, 1, 1, 1, 1, waits);
            send_frame(16'h0800, 16'd46, 1, 1, 1, 1, 1, waits);
        end
        e_pass += 200;
        drain();
        chk_cnts("toggle");
        @(posedge clk);
        #1;

        // cfg_enable low on the head, raised mid-frame: whole frame dropped.
        send_frame(16'h0800, 16'd150, 3, 3, 0, 1, 0, waits);
        cfg_enable = 1'b1;
        chk("cfg_mid_no_m_valid", m_tvalid, 0);
        e_drop += 1;
        drain();
        chk_cnts("cfg_mid");
        @(posedge clk);
        #1;

        // Reset pulsed in the middle of a forwarded frame.
        send_frame(16'h0800, 16'd400, 7, 3, 1, 1, 1, waits);
        drain();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        e_pass = 0; e_drop = 0; e_lerr = 0;
        chk("midrst_s_tready", s_tready, 0);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk_cnts("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_frame(16'h0800, 16'd400, 7, 7, 1, 1, 1, waits);
        e_pass = 1;
        drain();
        chk_cnts("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
